// File: rtl/dev_timer_pkg.sv
// dev_timer shared definitions: FSM encoding, register offsets,
// CTRL field positions and mode codes.
package dev_timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_CNT  = 2'b10,
        S_INT  = 2'b11
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'b00;
    localparam logic [1:0] ADDR_PRESET = 2'b01;
    localparam logic [1:0] ADDR_COUNT  = 2'b10;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM       = 3;
    localparam int CTRL_W        = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/dev_timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers,
// load/count/interrupt FSM and combinational read mux.
module dev_timer
    import dev_timer_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    state_t               state;
    state_t               state_nxt;
    logic [CTRL_W-1:0]    ctrl;
    logic [COUNT_W-1:0]   preset;
    logic [COUNT_W-1:0]   count;
    logic                 irq_flag;

    logic [1:0] sel;
    logic       wr_ctrl;
    logic       wr_preset;
    logic       en;
    logic       reload;
    logic       cnt_le1;

    logic do_load;
    logic do_dec;
    logic do_zero;
    logic do_set;
    logic do_clr_en;
    logic do_clr_irq;

    logic unused_addr;

    assign sel       = Addr[3:2];
    assign wr_ctrl   = WE && (sel == ADDR_CTRL);
    assign wr_preset = WE && (sel == ADDR_PRESET);
    assign en        = ctrl[CTRL_EN];
    assign reload    = ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD;
    assign cnt_le1   = count <= COUNT_W'(1);
    assign unused_addr = ^Addr[31:4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (en) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_CNT;
            S_CNT: begin
                if (!en)         state_nxt = S_IDLE;
                else if (cnt_le1) state_nxt = S_INT;
            end
            S_INT: state_nxt = reload ? S_LOAD : S_IDLE;
        endcase
    end

    always_comb begin
        do_load    = 1'b0;
        do_dec     = 1'b0;
        do_zero    = 1'b0;
        do_set     = 1'b0;
        do_clr_en  = 1'b0;
        do_clr_irq = 1'b0;
        unique case (state)
            S_IDLE: ;
            S_LOAD: begin
                do_load    = 1'b1;
                do_clr_irq = reload;
            end
            S_CNT: begin
                do_zero = en && cnt_le1;
                do_dec  = en && !cnt_le1;
            end
            S_INT: begin
                do_set    = 1'b1;
                do_clr_en = !reload;
            end
        endcase
    end

    // A CPU write to CTRL overrides the one-shot auto-disable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       ctrl <= '0;
        else if (wr_ctrl)   ctrl <= Din[CTRL_W-1:0];
        else if (do_clr_en) ctrl[CTRL_EN] <= 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       preset <= '0;
        else if (wr_preset) preset <= Din[COUNT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            unique case (1'b1)
                do_load: count <= preset;
                do_dec:  count <= count - COUNT_W'(1);
                do_zero: count <= '0;
                default: ;
            endcase
        end
    end

    // CPU clear beats a same-edge set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                  irq_flag <= 1'b0;
        else if (wr_ctrl || wr_preset) irq_flag <= 1'b0;
        else if (do_set)               irq_flag <= 1'b1;
        else if (do_clr_irq)           irq_flag <= 1'b0;
    end

    assign IRQ = irq_flag & ctrl[CTRL_IM];

    always_comb begin
        Dout = '0;
        unique case (sel)
            ADDR_CTRL:   Dout = 32'(ctrl);
            ADDR_PRESET: Dout = 32'(preset);
            ADDR_COUNT:  Dout = 32'(count);
            default:     Dout = '0;
        endcase
    end

endmodule

// File: tb/tb_dev_timer.sv
// Bench for dev_timer: directed table, corner sequences and
// randomized traffic against a behavioural timer model.
module tb_dev_timer;

    logic        clk;
    logic        reset_n;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int n_checks = 0;
    int n_err    = 0;

    dev_timer #(.COUNT_W(32)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .Addr   (Addr),
        .WE     (WE),
        .Din    (Din),
        .Dout   (Dout),
        .IRQ    (IRQ)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Behavioural model: phase 0 idle, 1 load, 2 counting, 3 expired
    logic        m_en;
    logic        m_im;
    logic [1:0]  m_mode;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    int          m_ph;

    function automatic void m_reset();
        m_en = 0; m_im = 0; m_mode = 0;
        m_preset = 0; m_count = 0; m_flag = 0; m_ph = 0;
    endfunction

    function automatic void m_step(logic we, logic [1:0] a, logic [31:0] d);
        bit rel;
        rel = (m_mode == 2'b01);
        case (m_ph)
            0: if (m_en) m_ph = 1;
            1: begin
                m_count = m_preset;
                m_ph = 2;
                if (rel) m_flag = 0;
            end
            2: begin
                if (!m_en) m_ph = 0;
                else if (m_count > 1) m_count = m_count - 1;
                else begin m_count = 0; m_ph = 3; end
            end
            default: begin
                m_flag = 1;
                if (rel) m_ph = 1;
                else begin m_en = 0; m_ph = 0; end
            end
        endcase
        if (we && a == 2'd0) begin
            m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; m_flag = 0;
        end
        if (we && a == 2'd1) begin
            m_preset = d; m_flag = 0;
        end
    endfunction

    function automatic logic [31:0] m_read(logic [1:0] a);
        case (a)
            2'd0:    return {28'h0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic rd(input string nm, input logic [1:0] a,
                      input logic [31:0] exp);
        Addr = {28'h0, a};
        #1;
        chk(nm, Dout, exp);
    endtask

    task automatic chk_irq(input string nm, input logic exp);
        chk(nm, {31'h0, IRQ}, {31'h0, exp});
    endtask

    task automatic tick(input logic we, input logic [1:0] a,
                        input logic [31:0] d);
        @(negedge clk);
        WE = we; Addr = {28'h0, a}; Din = d;
        @(posedge clk);
        m_step(we, a, d);
        #1;
        WE = 0; Din = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 2'd0, 32'h0);
    endtask

    task automatic do_reset;
        @(negedge clk);
        WE = 0;
        reset_n = 0;
        m_reset();
        #3;
        reset_n = 1;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  wa;
        logic [31:0] din;
        logic [1:0]  ra;
        logic [31:0] exp;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0; WE = 0; Addr = '0; Din = 0;
        m_reset();

        tbl[0]  = '{1, 2'd1, 32'h12345678, 2'd1, 32'h12345678, 0};
        tbl[1]  = '{1, 2'd2, 32'hFFFFFFFF, 2'd2, 32'h0, 0};
        tbl[2]  = '{1, 2'd3, 32'hFFFFFFFF, 2'd3, 32'h0, 0};
        tbl[3]  = '{1, 2'd0, 32'hFFFFFFF0, 2'd0, 32'h0, 0};
        tbl[4]  = '{1, 2'd0, 32'h0000000E, 2'd0, 32'hE, 0};
        tbl[5]  = '{1, 2'd1, 32'h00000002, 2'd1, 32'h2, 0};
        tbl[6]  = '{1, 2'd0, 32'hFFFFFFF1, 2'd0, 32'h1, 0};
        tbl[7]  = '{0, 2'd0, 32'h0, 2'd2, 32'h0, 0};
        tbl[8]  = '{0, 2'd0, 32'h0, 2'd2, 32'h2, 0};
        tbl[9]  = '{1, 2'd2, 32'hFFFFFFFF, 2'd2, 32'h1, 0};
        tbl[10] = '{0, 2'd0, 32'h0, 2'd2, 32'h0, 0};
        tbl[11] = '{0, 2'd0, 32'h0, 2'd0, 32'h0, 0};
        tbl[12] = '{1, 2'd0, 32'h00000008, 2'd2, 32'h0, 0};

        #7;
        for (int a = 0; a < 4; a++)
            rd($sformatf("reset_rd%0d", a), 2'(a), 32'h0);
        chk_irq("reset_irq", 0);
        do_reset();

        for (int i = 0; i < 13; i++) begin
            tick(tbl[i].we, tbl[i].wa, tbl[i].din);
            rd($sformatf("tbl%0d", i), tbl[i].ra, tbl[i].exp);
            chk_irq($sformatf("tbl%0d_irq", i), tbl[i].exp_irq);
        end

        // one-shot, PRESET=5
        do_reset();
        tick(1, 2'd1, 32'd5);
        tick(1, 2'd0, 32'h9);
        tick(0, 2'd0, 0);
        rd("os_load", 2'd2, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick(0, 2'd0, 0);
            rd($sformatf("os_cnt%0d", i), 2'd2, 32'(5 - i));
            chk_irq($sformatf("os_irq%0d", i), 0);
        end
        tick(0, 2'd0, 0);
        chk_irq("os_irq_set", 1);
        rd("os_ctrl", 2'd0, 32'h8);
        tick(0, 2'd0, 0);
        chk_irq("os_irq_hold", 1);
        tick(1, 2'd0, 32'h8);
        chk_irq("os_irq_clr", 0);

        // auto-reload, PRESET=3, period of 5
        do_reset();
        tick(1, 2'd1, 32'd3);
        tick(1, 2'd0, 32'hB);
        tick(0, 2'd0, 0);
        for (int k = 2; k <= 16; k++) begin
            int idx;
            idx = (k - 2) % 5;
            tick(0, 2'd0, 0);
            rd($sformatf("ar_cnt_e%0d", k), 2'd2,
               (idx <= 3) ? 32'(3 - idx) : 32'd0);
            chk_irq($sformatf("ar_irq_e%0d", k), idx == 4);
        end

        // asynchronous reset while counting
        #2;
        reset_n = 0;
        m_reset();
        #1;
        for (int a = 0; a < 4; a++)
            rd($sformatf("async_rd%0d", a), 2'(a), 32'h0);
        chk_irq("async_irq", 0);
        @(negedge clk);
        #1 reset_n = 1;

        // pause at COUNT=7, then re-enable reloads
        do_reset();
        tick(1, 2'd1, 32'd10);
        tick(1, 2'd0, 32'h1);
        idle(4);
        tick(1, 2'd0, 32'h0);
        rd("pause_at", 2'd2, 32'd7);
        idle(3);
        rd("pause_hold", 2'd2, 32'd7);
        tick(1, 2'd1, 32'd4);
        rd("pause_preset_idle", 2'd2, 32'd7);
        tick(1, 2'd0, 32'h1);
        tick(0, 2'd0, 0);
        rd("pause_load", 2'd2, 32'd7);
        tick(0, 2'd0, 0);
        rd("pause_reload", 2'd2, 32'd4);

        // CTRL write on the same edge as INT
        do_reset();
        tick(1, 2'd1, 32'd2);
        tick(1, 2'd0, 32'h9);
        idle(4);
        rd("col_pre", 2'd2, 32'd0);
        tick(1, 2'd0, 32'h9);
        rd("col_ctrl", 2'd0, 32'h9);
        chk_irq("col_irq", 0);
        tick(0, 2'd0, 0);
        tick(0, 2'd0, 0);
        rd("col_reload", 2'd2, 32'd2);

        // PRESET=0 still expires
        do_reset();
        tick(1, 2'd0, 32'h9);
        idle(5);
        chk_irq("p0_irq", 1);
        rd("p0_ctrl", 2'd0, 32'h8);

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic        we;
            logic [1:0]  a;
            logic [1:0]  ra;
            logic [31:0] d;
            logic [31:0] hi;
            we = ($urandom_range(0, 3) == 0);
            a  = 2'($urandom_range(0, 3));
            d  = $urandom;
            if (a == 2'd0 && $urandom_range(0, 2) != 0) d[0] = 1'b1;
            if (a == 2'd1) d = 32'($urandom_range(0, 6));
            tick(we, a, d);
            ra = 2'($urandom_range(0, 3));
            hi = $urandom;
            Addr = {hi[27:0], ra};
            #1;
            chk($sformatf("rnd%0d_rd%0d", n, ra), Dout, m_read(ra));
            chk($sformatf("rnd%0d_irq", n), {31'h0, IRQ},
                {31'h0, m_flag & m_im});
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
